// File: rtl/triplet_collector_if.sv
// Stream bundle between the sample source, the triplet collector and the
// three-cell sorter.
//   in_data/in_valid/in_ready/in_last : sample stream into the collector
//   out_x1/x2/x3/out_valid/out_ready  : triplet stream toward the sorter
//   out_partial                        : triplet carries at least one pad slot
// slave  : the collector's view (consumes samples, produces triplets)
// master : the surrounding environment's view
`timescale 1ns/1ps
interface triplet_collector_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [WIDTH-1:0] out_x1;
  logic [WIDTH-1:0] out_x2;
  logic [WIDTH-1:0] out_x3;
  logic             out_valid;
  logic             out_ready;
  logic             out_partial;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_x1, out_x2, out_x3, out_valid, out_partial
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_x1, out_x2, out_x3, out_valid, out_partial
  );
endinterface

// File: rtl/triplet_collector.sv
// Groups a WIDTH-bit sample stream into triplets for the sorting stage.
// Triplets are presented oldest-first on out_x1/x2/x3 from a single output
// register. SLIDING=0 emits one triplet per three samples; SLIDING=1 emits one
// per sample once two samples of the frame are buffered. A sample flagged
// in_last closes the frame: a short triplet is padded with PAD and marked
// out_partial, and the buffer is cleared.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  triplet_collector_if.slave (in_* sample stream, out_* triplet stream)
`timescale 1ns/1ps
module triplet_collector #(
  parameter int               WIDTH   = 8,
  parameter bit               SLIDING = 1'b0,
  parameter logic [WIDTH-1:0] PAD     = '0
) (
  input  logic                clk,
  input  logic                rst,
  triplet_collector_if.slave  bus
);

  typedef enum logic [1:0] {
    CNT0 = 2'd0,
    CNT1 = 2'd1,
    CNT2 = 2'd2
  } fill_t;

  fill_t            cnt;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic             accept;

  // Accepting only when the output register is free (or draining this cycle)
  // is what keeps the staging registers from being overwritten under stall.
  assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= CNT0;
      s0              <= '0;
      s1              <= '0;
      bus.out_x1      <= '0;
      bus.out_x2      <= '0;
      bus.out_x3      <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_partial <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      // An emit below overrides the drain above, so drain+reload keeps
      // out_valid high with no bubble.
      if (accept) begin
        unique case (cnt)
          CNT0: begin
            if (bus.in_last) begin
              bus.out_x1      <= bus.in_data;
              bus.out_x2      <= PAD;
              bus.out_x3      <= PAD;
              bus.out_partial <= 1'b1;
              bus.out_valid   <= 1'b1;
            end else begin
              s0  <= bus.in_data;
              cnt <= CNT1;
            end
          end
          CNT1: begin
            if (bus.in_last) begin
              bus.out_x1      <= s0;
              bus.out_x2      <= bus.in_data;
              bus.out_x3      <= PAD;
              bus.out_partial <= 1'b1;
              bus.out_valid   <= 1'b1;
              cnt             <= CNT0;
            end else begin
              s1  <= bus.in_data;
              cnt <= CNT2;
            end
          end
          CNT2: begin
            bus.out_x1      <= s0;
            bus.out_x2      <= s1;
            bus.out_x3      <= bus.in_data;
            bus.out_partial <= 1'b0;
            bus.out_valid   <= 1'b1;
            if (SLIDING && !bus.in_last) begin
              s0 <= s1;
              s1 <= bus.in_data;
            end else begin
              cnt <= CNT0;
            end
          end
          default: cnt <= CNT0;
        endcase
      end
    end
  end

endmodule
